// File: rtl/period_meter_pkg.sv
// Shared types for period_meter: measurement FSM states and the result record.
// RES_W is the widest supported WIDTH; narrower builds truncate on the way out.
package period_meter_pkg;

  localparam int RES_W = 32;

  typedef enum logic {
    ARM  = 1'b0,
    MEAS = 1'b1
  } state_e;

  typedef struct packed {
    logic [RES_W-1:0] period;
    logic [RES_W-1:0] highTime;
    logic             timeoutFlag;
    logic             overrun;
  } meas_res_t;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Synchroniser chain for an asynchronous input plus one edge-detect register.
// Produces single-cycle rise/fall pulses aligned to the synchronised level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkIn,
  input  logic reset,
  input  logic sigIn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sigIn};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period (and high time when PERIOD_METER_DUTY_EN is defined) of a slow
// asynchronous input; results leave through a one-entry valid/ready buffer.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 100_000_000
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             sigIn,
  input  logic             measReady,
  output logic             measValid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] highTime,
  output logic             timeoutFlag,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);

  logic             rise;
  logic             level_unused;
  logic [WIDTH-1:0] hi_now;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  meas_res_t        buf_q, buf_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  meas_res_t        res;
  logic             res_vld;
  logic             load;

`ifdef PERIOD_METER_DUTY_EN
  logic             fall;
  logic [WIDTH-1:0] hi_cap_q, hi_cap_d;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkIn (clkIn),
    .reset (reset),
    .sigIn (sigIn),
    .level (level_unused),
    .rise  (rise),
    .fall  (fall)
  );

  // Keeps the last captured value if a period passes without a falling edge.
  always_comb begin
    hi_cap_d = hi_cap_q;
    if (state_q == MEAS && fall) hi_cap_d = cnt_q;
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) hi_cap_q <= '0;
    else       hi_cap_q <= hi_cap_d;
  end

  assign hi_now = hi_cap_q;
`else
  logic fall_unused;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkIn (clkIn),
    .reset (reset),
    .sigIn (sigIn),
    .level (level_unused),
    .rise  (rise),
    .fall  (fall_unused)
  );

  assign hi_now = '0;
`endif

  // A rise on the saturation cycle takes priority, so a period of exactly TIMEOUT is a measurement.
  always_comb begin
    state_d = state_q;
    res     = '0;
    res_vld = 1'b0;
    if (rise)                cnt_d = WIDTH'(1);
    else if (cnt_q == TO_VAL) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + WIDTH'(1);
    case (state_q)
      ARM: begin
        if (rise) state_d = MEAS;
      end
      MEAS: begin
        if (rise) begin
          res_vld      = 1'b1;
          res.period   = RES_W'(cnt_q);
          res.highTime = RES_W'(hi_now);
        end else if (cnt_q == TO_VAL) begin
          res_vld         = 1'b1;
          res.period      = RES_W'(TO_VAL);
          res.timeoutFlag = 1'b1;
          state_d         = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_comb begin
    load    = res_vld && (!valid_q || measReady);
    valid_d = valid_q;
    buf_d   = buf_q;
    drop_d  = drop_q;
    if (load) begin
      buf_d         = res;
      buf_d.overrun = drop_q;
      valid_d       = 1'b1;
      drop_d        = 1'b0;
    end else begin
      if (valid_q && measReady) valid_d = 1'b0;
      if (res_vld)              drop_d  = 1'b1;
    end
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state_q <= ARM;
      cnt_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign measValid   = valid_q;
  assign period      = WIDTH'(buf_q.period);
  assign highTime    = WIDTH'(buf_q.highTime);
  assign timeoutFlag = buf_q.timeoutFlag;
  assign overrun     = buf_q.overrun;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a result scoreboard; TIMEOUT shrunk to 50.
module tb_period_meter;

  localparam int W  = 32;
  localparam int TO = 50;

  logic         clkIn = 1'b0;
  logic         reset;
  logic         sigIn;
  logic         measReady;
  logic         measValid;
  logic [W-1:0] period;
  logic [W-1:0] highTime;
  logic         timeoutFlag;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] p;
    logic [31:0] h;
    logic        t;
    logic        o;
  } exp_t;

  exp_t sb[$];

  period_meter #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clkIn       (clkIn),
    .reset       (reset),
    .sigIn       (sigIn),
    .measReady   (measReady),
    .measValid   (measValid),
    .period      (period),
    .highTime    (highTime),
    .timeoutFlag (timeoutFlag),
    .overrun     (overrun)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [31:0] exp_hi(input int h);
`ifdef PERIOD_METER_DUTY_EN
    return 32'(h);
`else
    return 32'(h) & 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input int h, input bit t, input bit o);
    exp_t e;
    e.p = 32'(p);
    e.h = (t) ? 32'd0 : exp_hi(h);
    e.t = t;
    e.o = o;
    sb.push_back(e);
  endtask

  // One call = n periods, each high for h cycles then low for the rest.
  task automatic drive_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < p; c++) begin
        sigIn = (c < h);
        @(posedge clkIn);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    sigIn = 1'b0;
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  // A transfer is seen on the negedge preceding the accepting posedge.
  always @(negedge clkIn) begin
    if (!reset && measValid && measReady) begin
      check("result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("period",      64'(period),      64'(e.p));
        check("highTime",    64'(highTime),    64'(e.h));
        check("timeoutFlag", 64'(timeoutFlag), 64'(e.t));
        check("overrun",     64'(overrun),     64'(e.o));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    sigIn     = 1'b0;
    measReady = 1'b1;
    repeat (3) @(posedge clkIn);
    #1;
    check("rst_measValid",   64'(measValid),   64'd0);
    check("rst_period",      64'(period),      64'd0);
    check("rst_highTime",    64'(highTime),    64'd0);
    check("rst_timeoutFlag", 64'(timeoutFlag), 64'd0);
    check("rst_overrun",     64'(overrun),     64'd0);
    reset = 1'b0;
    idle(5);

    // 10/5 divider, consumer always ready, then input stops low.
    for (int i = 0; i < 3; i++) push(10, 5, 1'b0, 1'b0);
    push(TO, 0, 1'b1, 1'b0);
    drive_wave(10, 5, 4);
    idle(70);

    // Consumer stalled across several periods of 8: first result held, later ones dropped.
    measReady = 1'b0;
    push(8, 4, 1'b0, 1'b0);
    push(8, 4, 1'b0, 1'b1);
    push(TO, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) measReady = 1'b1;
      drive_wave(8, 4, 1);
      if (i == 3) begin
        check("hold_measValid", 64'(measValid), 64'd1);
        check("hold_period",    64'(period),    64'd8);
        check("hold_highTime",  64'(highTime),  64'(exp_hi(4)));
        check("hold_overrun",   64'(overrun),   64'd0);
      end
    end
    idle(70);

    // Reset mid-measurement with a result waiting in the buffer.
    measReady = 1'b0;
    drive_wave(10, 5, 2);
    sigIn = 1'b1;
    repeat (3) @(posedge clkIn);
    #1;
    check("pre_rst_measValid", 64'(measValid), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_measValid", 64'(measValid), 64'd0);
    check("mid_rst_period",    64'(period),    64'd0);
    repeat (2) @(posedge clkIn);
    #1;
    sigIn     = 1'b0;
    reset     = 1'b0;
    measReady = 1'b1;
    idle(7);
    push(12, 6, 1'b0, 1'b0);
    push(12, 6, 1'b0, 1'b0);
    push(TO, 0, 1'b1, 1'b0);
    drive_wave(12, 6, 3);
    idle(70);

    // Period exactly TIMEOUT: the rise beats the timeout.
    push(TO, 25, 1'b0, 1'b0);
    push(TO, 25, 1'b0, 1'b0);
    push(TO, 0, 1'b1, 1'b0);
    drive_wave(TO, 25, 3);
    idle(70);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clkIn);
    #1;
    check("sb_drained",     64'(sb.size()), 64'd0);
    check("end_measValid",  64'(measValid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
